mips8_multicycle_control: RTL and testbench
===========================================

Name: mips8_multicycle_control

Overview:
Moore-style main control FSM for the 8-bit multicycle MIPS processor. It sits directly upstream of the datapath. It consumes the opcode field of the instruction register and the ALU zero flag, and drives every datapath mux select and write enable. Instructions are fetched one byte per cycle over four fetch cycles, then decoded and executed over 2-4 further cycles.

Parameters:
OP_W, 6, opcode width (instruction bits 31:26)
ST_W, 4, state register width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
op  input  6  opcode from instruction register
zero  input  1  ALU zero flag from datapath
memread  output  1  memory read enable
memwrite  output  1  memory write enable
iord  output  1  address mux: 0=PC, 1=ALUOut
irwrite  output  4  one-hot byte write enable into IR
alusrca  output  1  ALU A: 0=PC, 1=reg A
alusrcb  output  2  ALU B: 00=reg B, 01=const 1, 10=imm, 11=imm (branch offset)
aluop  output  2  00=add, 01=sub, 10=use funct
pcsource  output  2  00=ALU result, 01=ALUOut, 10=jump target
pcen  output  1  PC write enable
regwrite  output  1  register file write enable
regdst  output  1  dest reg: 0=rt, 1=rd
memtoreg  output  1  write-back: 0=ALUOut, 1=MDR
instr_done  output  1  high during final state of each instruction
illegal_op  output  1  sticky: unsupported opcode decoded
state  output  4  current state (debug/verification)

Behaviour:
- Clock and reset: single clock domain. reset_n low asynchronously forces state=FETCH1 and illegal_op=0, including mid-instruction. The first active edge after release advances from FETCH1.
- State encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 is unreachable; if entered, it goes to FETCH1 with all outputs 0.
- Opcodes: RTYPE=000000, J=000010, BEQ=000100, ADDI=001000, LB=100000, SB=101000.
- Transitions:
  - FETCH1 through FETCH4 are sequential; FETCH4 goes to DECODE.
  - DECODE by op: LB/SB to MEMADR; RTYPE to RTYPEEX; BEQ to BEQEX; J to JEX; ADDI to ADDIEX; any other opcode to FETCH1 with illegal_op set.
  - MEMADR goes to LBRD if op=LB, else SBWR. LBRD goes to LBWR.
  - RTYPEEX goes to RTYPEWR; ADDIEX goes to ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX and ADDIWR go to FETCH1.
- Outputs are a combinational decode of the state register only (Moore). The one exception is pcen = pcwrite | (branch & zero), where pcwrite and branch are internal decodes. Any signal not listed for a state is 0.
  - FETCHk (k=1..4): memread=1, irwrite=1<<(k-1), alusrcb=01, pcwrite=1.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, pcsource=01, branch=1.
  - JEX: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- Reset output values: because reset forces FETCH1, during and after reset memread=1, irwrite=0001, alusrcb=01 and pcen=1; all other outputs are 0.
- instr_done=1 in LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR, and in DECODE when the opcode is illegal.
- Latency (cycles from FETCH1 to the return to FETCH1): LB=8, SB=7, RTYPE=7, ADDI=7, BEQ=6, J=6, illegal=5.
- memread and memwrite are never both 1 in any state.
- op is sampled only in DECODE and MEMADR; the datapath holds IR stable between fetches.
- illegal_op is set on the DECODE edge that sees the bad opcode and is cleared only by reset.

Decomposition:
- Shared package mips8_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALUOP, ALUSRCB and PCSOURCE encodings (also used by the datapath and the ALU control).
- One sub-module is natural: mips8_control_decode, a pure combinational state-to-control-word lookup. The top module keeps the state register, next-state logic, pcen and illegal_op.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> state=0, irwrite=0001, memread=1, pcen=1, illegal_op=0. Release -> state steps 0,1,2,3,4 with irwrite 0001,0010,0100,1000,0000.
- LB (op=100000) -> states 0-3,4,5,6,7,0. LBRD shows memread=1, iord=1. LBWR shows regwrite=1, memtoreg=1, instr_done=1. Total 8 cycles.
- BEQ (op=000100): zero=1 in BEQEX -> pcen=1, pcsource=01, aluop=01. Repeat with zero=0 -> pcen=0. Toggling zero outside BEQEX and FETCH has no effect on pcen.
- RTYPE, then ADDI, then J back-to-back -> RTYPEWR regdst=1, ADDIWR regdst=0, JEX pcen=1 with pcsource=10. Cycle counts are 7, 7, 6.
- SB (op=101000) -> SBWR memwrite=1, iord=1, memread=0. Next state FETCH1 after 7 cycles.
- Illegal op=111111 -> DECODE goes to FETCH1, illegal_op=1 and stays 1 through later valid instructions. Assert reset_n low during MEMADR of an LB -> state=0 immediately and illegal_op=0.

Source files
------------

// File: rtl/mips8_pkg.sv
// Shared encodings for the multicycle MIPS-8 control path: FSM states, opcodes and mux selects.
// Constants only; no latency, no backpressure.
package mips8_pkg;

    localparam int OP_W_C = 6;
    localparam int ST_W_C = 4;

    typedef enum logic [ST_W_C-1:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_e;

    localparam logic [OP_W_C-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W_C-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W_C-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W_C-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W_C-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W_C-1:0] OP_SB    = 6'b101000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REGB = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OP_W_C-1:0] o);
        return o inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LB, OP_SB};
    endfunction

endpackage

// File: rtl/mips8_control_decode.sv
// State-to-control-word lookup for the MIPS-8 control FSM; purely combinational, zero latency.
// No backpressure; the unused state code decodes to an all-zero word.
module mips8_control_decode
    import mips8_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH1: begin ctrl.memread = 1'b1; ctrl.irwrite = 4'b0001; ctrl.alusrcb = ALUSRCB_ONE; ctrl.pcwrite = 1'b1; end
            S_FETCH2: begin ctrl.memread = 1'b1; ctrl.irwrite = 4'b0010; ctrl.alusrcb = ALUSRCB_ONE; ctrl.pcwrite = 1'b1; end
            S_FETCH3: begin ctrl.memread = 1'b1; ctrl.irwrite = 4'b0100; ctrl.alusrcb = ALUSRCB_ONE; ctrl.pcwrite = 1'b1; end
            S_FETCH4: begin ctrl.memread = 1'b1; ctrl.irwrite = 4'b1000; ctrl.alusrcb = ALUSRCB_ONE; ctrl.pcwrite = 1'b1; end
            // Branch target is precomputed here so BEQEX can pick it from ALUOut.
            S_DECODE:  ctrl.alusrcb = ALUSRCB_BOFF;
            S_MEMADR:  begin ctrl.alusrca = 1'b1; ctrl.alusrcb = ALUSRCB_IMM; end
            S_LBRD:    begin ctrl.memread = 1'b1; ctrl.iord = 1'b1; end
            S_LBWR:    begin ctrl.regwrite = 1'b1; ctrl.memtoreg = 1'b1; ctrl.instr_done = 1'b1; end
            S_SBWR:    begin ctrl.memwrite = 1'b1; ctrl.iord = 1'b1; ctrl.instr_done = 1'b1; end
            S_RTYPEEX: begin ctrl.alusrca = 1'b1; ctrl.aluop = ALUOP_FUNCT; end
            S_RTYPEWR: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.instr_done = 1'b1; end
            S_BEQEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsource   = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JEX:     begin ctrl.pcwrite = 1'b1; ctrl.pcsource = PCSRC_JUMP; ctrl.instr_done = 1'b1; end
            S_ADDIEX:  begin ctrl.alusrca = 1'b1; ctrl.alusrcb = ALUSRCB_IMM; end
            S_ADDIWR:  begin ctrl.regwrite = 1'b1; ctrl.instr_done = 1'b1; end
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips8_multicycle_control.sv
// Moore main-control FSM for the multicycle MIPS-8: 5-8 cycles per instruction, outputs follow state.
// No backpressure; op is sampled only in DECODE/MEMADR, zero only gates the branch PC write.
module mips8_multicycle_control
    import mips8_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    output logic            memread,
    output logic            memwrite,
    output logic            iord,
    output logic [3:0]      irwrite,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsource,
    output logic            pcen,
    output logic            regwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;
    logic   op_legal;

    assign op_legal = is_legal_op(op);

    always_comb begin
        state_d   = S_FETCH1;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH1:  state_d = S_FETCH2;
            S_FETCH2:  state_d = S_FETCH3;
            S_FETCH3:  state_d = S_FETCH4;
            S_FETCH4:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
            S_ADDIEX:  state_d = S_ADDIWR;
            default:   state_d = S_FETCH1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mips8_control_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsource   = ctrl.pcsource;
    assign regwrite   = ctrl.regwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    // zero only matters in BEQEX, the only state that raises branch.
    assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
    assign instr_done = ctrl.instr_done | ((state_q == S_DECODE) & ~op_legal);
    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips8_multicycle_control.sv
// Randomized self-checking bench for mips8_multicycle_control against an instruction-level model.
module tb_mips8_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_LB    = 6'b100000;
    localparam logic [5:0] T_SB    = 6'b101000;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    logic       clock;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg;
    logic       instr_done, illegal_op;
    logic [3:0] irwrite, state;
    logic [1:0] alusrcb, aluop, pcsource;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_pos   = 0;
    logic m_ill   = 1'b0;

    mips8_multicycle_control dut (
        .clock(clock), .reset_n(reset_n), .op(op), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
        .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic tb_legal(input logic [5:0] o);
        return (o == T_RTYPE) || (o == T_J) || (o == T_BEQ) || (o == T_ADDI) || (o == T_LB) || (o == T_SB);
    endfunction

    // Cycles from FETCH1 back to FETCH1 for each instruction class.
    function automatic int path_len(input logic [5:0] o);
        case (o)
            T_LB:                  return 8;
            T_SB, T_RTYPE, T_ADDI: return 7;
            T_BEQ, T_J:            return 6;
            default:               return 5;
        endcase
    endfunction

    // Which state the instruction occupies at cycle pos of its execution.
    function automatic int seq_state(input logic [5:0] o, input int pos);
        if (pos < 5) return pos;
        case (o)
            T_LB:    return pos;
            T_SB:    return (pos == 5) ? 5 : 8;
            T_RTYPE: return (pos == 5) ? 9 : 10;
            T_ADDI:  return (pos == 5) ? 13 : 14;
            T_BEQ:   return 11;
            T_J:     return 12;
            default: return 0;
        endcase
    endfunction

    function automatic obs_t model_out(input int st, input logic z, input logic [5:0] o, input logic ill);
        obs_t e;
        e            = '0;
        e.state      = 4'(st);
        e.illegal_op = ill;
        case (st)
            0, 1, 2, 3: begin e.memread = 1; e.irwrite = 4'b0001 << st; e.alusrcb = 2'b01; e.pcen = 1; end
            4:  begin e.alusrcb = 2'b11; e.instr_done = !tb_legal(o); end
            5:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            6:  begin e.memread = 1; e.iord = 1; end
            7:  begin e.regwrite = 1; e.memtoreg = 1; e.instr_done = 1; end
            8:  begin e.memwrite = 1; e.iord = 1; e.instr_done = 1; end
            9:  begin e.alusrca = 1; e.aluop = 2'b10; end
            10: begin e.regwrite = 1; e.regdst = 1; e.instr_done = 1; end
            11: begin e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z; e.instr_done = 1; end
            12: begin e.pcen = 1; e.pcsource = 2'b10; e.instr_done = 1; end
            13: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            14: begin e.regwrite = 1; e.instr_done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.memread = memread;   s.memwrite = memwrite; s.iord = iord;       s.irwrite = irwrite;
        s.alusrca = alusrca;   s.alusrcb = alusrcb;   s.aluop = aluop;     s.pcsource = pcsource;
        s.pcen = pcen;         s.regwrite = regwrite; s.regdst = regdst;   s.memtoreg = memtoreg;
        s.instr_done = instr_done; s.illegal_op = illegal_op; s.state = state;
        return s;
    endfunction

    // One clock of stimulus: drive zero, observe mid-cycle, advance the model across the edge.
    task automatic step(input logic z, output obs_t got, output obs_t exp);
        int st;
        zero = z;
        st   = seq_state(op, m_pos);
        @(negedge clock);
        got = sample();
        exp = model_out(st, z, op, m_ill);
        @(posedge clock);
        if (st == 4 && !tb_legal(op)) m_ill = 1'b1;
        m_pos++;
        if (m_pos >= path_len(op)) m_pos = 0;
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        logic [3:0] irw;
        reset_n = 1'b0; op = T_LB; zero = 1'b0; m_pos = 0; m_ill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clock);
            got = sample();
            exp = model_out(0, zero, op, 1'b0);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_hold[%0d] got=%h expected=%h", i, got, exp); end
        end
        @(posedge clock); #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_release[%0d] got=%h expected=%h", i, got, exp); end
            if (i < 5) begin
                irw = (i < 4) ? (4'b0001 << i) : 4'b0000;
                n_tests++;
                if (got.state !== 4'(i) || got.irwrite !== irw) begin
                    n_fail++;
                    $display("FAIL reset_walk[%0d] state=%0d irwrite=%b expected state=%0d irwrite=%b", i, got.state, got.irwrite, i, irw);
                end
            end
        end
    endtask

    task automatic test_lb();
        obs_t got, exp;
        op = T_LB;
        for (int i = 0; i < path_len(op); i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL lb[%0d] got=%h expected=%h", i, got, exp); end
        end
        n_tests++;
        if (got.state !== 4'd7 || !got.memtoreg || !got.instr_done) begin
            n_fail++; $display("FAIL lb_final state=%0d memtoreg=%b done=%b expected 7/1/1", got.state, got.memtoreg, got.instr_done);
        end
    endtask

    task automatic test_beq();
        obs_t got, exp;
        logic zb, z;
        op = T_BEQ;
        for (int r = 0; r < 2; r++) begin
            zb = (r == 0);
            for (int i = 0; i < path_len(op); i++) begin
                z = (i == 5) ? zb : 1'($urandom_range(0, 1));
                step(z, got, exp);
                n_tests++;
                if (got !== exp) begin n_fail++; $display("FAIL beq%0d[%0d] got=%h expected=%h", r, i, got, exp); end
                if (i == 5) begin
                    n_tests++;
                    if (got.pcen !== zb) begin n_fail++; $display("FAIL beq_pcen zero=%b pcen=%b expected=%b", zb, got.pcen, zb); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        logic [5:0] ops [3];
        int lat [3];
        int cnt;
        ops = '{T_RTYPE, T_ADDI, T_J};
        lat = '{7, 7, 6};
        for (int k = 0; k < 3; k++) begin
            op  = ops[k];
            cnt = 0;
            for (int i = 0; i < 12; i++) begin
                step(1'($urandom_range(0, 1)), got, exp);
                cnt++;
                n_tests++;
                if (got !== exp) begin n_fail++; $display("FAIL b2b%0d[%0d] got=%h expected=%h", k, i, got, exp); end
                if (got.instr_done) break;
            end
            n_tests++;
            if (cnt !== lat[k]) begin n_fail++; $display("FAIL b2b_latency op=%b cycles=%0d expected=%0d", ops[k], cnt, lat[k]); end
        end
    endtask

    task automatic test_sb();
        obs_t got, exp;
        op = T_SB;
        for (int i = 0; i < path_len(op); i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL sb[%0d] got=%h expected=%h", i, got, exp); end
        end
        n_tests++;
        if (got.memwrite !== 1'b1 || got.memread !== 1'b0 || got.iord !== 1'b1) begin
            n_fail++; $display("FAIL sb_write memwrite=%b memread=%b iord=%b expected 1/0/1", got.memwrite, got.memread, got.iord);
        end
    endtask

    task automatic test_random();
        obs_t got, exp;
        logic [5:0] tbl [6];
        int pick;
        tbl = '{T_RTYPE, T_J, T_BEQ, T_ADDI, T_LB, T_SB};
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 7);
            op   = (pick < 6) ? tbl[pick] : 6'($urandom);
            for (int i = 0; i < path_len(op); i++) begin
                step(1'($urandom_range(0, 1)), got, exp);
                n_tests++;
                if (got !== exp) begin n_fail++; $display("FAIL rand%0d op=%b [%0d] got=%h expected=%h", n, op, i, got, exp); end
                n_tests++;
                if (got.memread && got.memwrite) begin n_fail++; $display("FAIL rand_rdwr both memread and memwrite high in state %0d", got.state); end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t got, exp;
        op = 6'b111111;
        for (int i = 0; i < path_len(op); i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL illegal[%0d] got=%h expected=%h", i, got, exp); end
        end
        op = T_ADDI;
        for (int i = 0; i < path_len(op); i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL illegal_after[%0d] got=%h expected=%h", i, got, exp); end
        end
        n_tests++;
        if (got.illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky illegal_op=%b expected=1", got.illegal_op); end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        op = T_LB;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL mid_pre[%0d] got=%h expected=%h", i, got, exp); end
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset state=%0d illegal_op=%b expected 0/0", state, illegal_op);
        end
        m_pos = 0; m_ill = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        for (int i = 0; i < path_len(op); i++) begin
            step(1'($urandom_range(0, 1)), got, exp);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL mid_restart[%0d] got=%h expected=%h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_beq();
        test_back_to_back();
        test_sb();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
